xor_gate_using_mux: RTL and testbench
=====================================

Name: xor_gate_using_mux

Overview:
- Computes bitwise XOR of two operands using only 2:1 multiplexers; no XOR/AND/OR/NOT operators in the datapath.
- Provides a combinational result plus a one-cycle registered copy with a valid flag.
- Serves as a leaf primitive in the combinational-logic exercise set and as a mux-only XOR cell for larger datapaths.

Parameters:
- WIDTH, 1, operand and result width in bits; legal range is 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- o  output  WIDTH  combinational a XOR b.
- in_valid  input  1  qualifies a/b for capture into the register stage.
- o_q  output  WIDTH  registered result.
- out_valid  output  1  o_q holds a captured result.

Behaviour:
- Combinational path, per bit i:
  - nb[i] = mux(sel=b[i], d0=1'b1, d1=1'b0).
  - o[i] = mux(sel=a[i], d0=b[i], d1=nb[i]).
- Combinational path properties:
  - o is independent of clk, rst_n and in_valid.
  - o settles within the same delta step as input changes.
  - o is valid during reset.
- Truth table per bit (a,b -> o): 00->0, 01->1, 10->1, 11->0.
- X/Z on a[i] or b[i] may propagate to o[i]. No X-masking is required.
- Register stage, on rst_n falling edge, asynchronously:
  - o_q = 0.
  - out_valid = 0.
- Register stage, on rising clk while rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1: o_q <= o.
  - If in_valid=0: o_q holds its previous value.
- Latency: o has 0 cycles; o_q/out_valid have 1 cycle.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Reset asserted mid-stream:
  - Outputs clear immediately, without waiting for clk.
  - The first capture after release happens on the first rising clk with rst_n=1.
- Reset release coincident with a clk edge: that edge is ignored. Registers update from the next edge.
- in_valid and a/b changing at the same time as a clk edge: values are sampled as they stand before the edge (standard nonblocking semantics).

Decomposition:
- Shared package: no typedefs required. Optional localparam for the maximum WIDTH check.
- Sub-module mux_2to1 (sel, d0, d1 -> y, 1 bit, combinational y = sel ? d1 : d0).
- Top instantiates 2*WIDTH mux_2to1 cells via a generate loop, plus one always_ff block with async reset for o_q/out_valid.
- WIDTH range is checked with an elaboration-time assertion.

Test Plan:
- Exhaustive WIDTH=1, combinational: (a,b) = (0,0),(0,1),(1,0),(1,1), wait 1 time unit -> o = 0,1,1,0. Check with !== against a^b. Also check this under rst_n=0.
- Registered capture, WIDTH=1: rst_n=1, in_valid=1, a=1, b=0 at an edge -> next cycle o_q=1, out_valid=1. Then in_valid=0, a=b=1 -> out_valid=0, o_q stays 1.
- Async reset: o_q=1, out_valid=1, then drop rst_n between clock edges -> o_q=0 and out_valid=0 immediately. Meanwhile o continues to track a^b.
- Streaming, WIDTH=8: in_valid=1 for 4 cycles with (a,b) = (8'hFF,8'h0F),(8'hAA,8'h55),(8'h00,8'h00),(8'h3C,8'h3C) -> o_q sequence 8'hF0, 8'hFF, 8'h00, 8'h00, each one cycle later, with out_valid high throughout.
- Reset release on a clock edge: deassert rst_n coincident with a rising clk with in_valid=1, a=1, b=0 -> o_q stays 0 on that edge and becomes 1 on the following edge.
- Randomized WIDTH=16: 1000 random a/b/in_valid vectors -> o == a^b every step; o_q/out_valid match a 1-cycle reference model.

Source files
------------

// File: rtl/xor_gate_using_mux_pkg.sv
// Shared constants for the mux-only XOR cell: the legal operand width range.
package xor_gate_using_mux_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/mux_2to1.sv
// Single-bit 2:1 multiplexer; the only logic primitive the XOR cell is built from.
module mux_2to1 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/xor_gate_using_mux.sv
// Bitwise XOR built purely from 2:1 muxes, with a combinational result and a
// one-cycle registered copy qualified by in_valid/out_valid.
module xor_gate_using_mux
  import xor_gate_using_mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  input  logic             in_valid,
  output logic [WIDTH-1:0] o_q,
  output logic             out_valid
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("xor_gate_using_mux: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  logic [WIDTH-1:0] nb;

  // One mux inverts b[i]; the second picks b[i] or its inverse based on a[i].
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2to1 u_inv (
      .sel (b[i]),
      .d0  (1'b1),
      .d1  (1'b0),
      .y   (nb[i])
    );

    mux_2to1 u_sel (
      .sel (a[i]),
      .d0  (b[i]),
      .d1  (nb[i]),
      .y   (o[i])
    );
  end

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values; o_q has no else-branch on purpose and simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o_q <= o;
      end
    end
  end

endmodule

// File: tb/tb_xor_gate_using_mux.sv
// Self-checking bench for xor_gate_using_mux at WIDTH 1, 8 and 16, using a
// scoreboard of expected registered results and immediate assertions.
module tb_xor_gate_using_mux;

  typedef struct {
    logic        vld;
    logic [63:0] q;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [0:0]  a1,  b1,  o1,  q1;
  logic [7:0]  a8,  b8,  o8,  q8;
  logic [15:0] a16, b16, o16, q16;
  logic        v1, v8, v16, ov1, ov8, ov16;

  exp_t        sb1[$], sb8[$], sb16[$];
  logic [63:0] model_q [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xor_gate_using_mux #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .o(o1),
    .in_valid(v1), .o_q(q1), .out_valid(ov1)
  );

  xor_gate_using_mux #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .o(o8),
    .in_valid(v8), .o_q(q8), .out_valid(ov8)
  );

  xor_gate_using_mux #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .o(o16),
    .in_valid(v16), .o_q(q16), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 8 : 16;
  endfunction

  function automatic logic [63:0] obs_o(input int inst);
    case (inst)
      0:       return 64'(o1);
      1:       return 64'(o8);
      default: return 64'(o16);
    endcase
  endfunction

  function automatic logic [63:0] obs_q(input int inst);
    case (inst)
      0:       return 64'(q1);
      1:       return 64'(q8);
      default: return 64'(q16);
    endcase
  endfunction

  function automatic logic obs_v(input int inst);
    case (inst)
      0:       return ov1;
      1:       return ov8;
      default: return ov16;
    endcase
  endfunction

  task automatic sb_clear();
    sb1.delete();
    sb8.delete();
    sb16.delete();
    for (int i = 0; i < 3; i++) model_q[i] = '0;
  endtask

  // Drive one vector at the falling edge, check o after settling, and push the
  // register-stage result expected after the next rising edge.
  task automatic drive(input int inst, input logic [63:0] a, input logic [63:0] b,
                       input logic v, input string tag);
    logic [63:0] mask;
    logic [63:0] want_o;
    exp_t        e;
    @(negedge clk);
    case (inst)
      0:       begin a1  = a[0:0];  b1  = b[0:0];  v1  = v; end
      1:       begin a8  = a[7:0];  b8  = b[7:0];  v8  = v; end
      default: begin a16 = a[15:0]; b16 = b[15:0]; v16 = v; end
    endcase
    mask   = (64'd1 << width_of(inst)) - 64'd1;
    want_o = (a ^ b) & mask;
    if (v) model_q[inst] = want_o;
    e.vld = v;
    e.q   = model_q[inst];
    case (inst)
      0:       sb1.push_back(e);
      1:       sb8.push_back(e);
      default: sb16.push_back(e);
    endcase
    #1;
    check({tag, "_o"}, obs_o(inst), want_o);
  endtask

  task automatic sample(input int inst, input string tag);
    exp_t e;
    int   depth;
    @(posedge clk);
    #1;
    case (inst)
      0:       depth = sb1.size();
      1:       depth = sb8.size();
      default: depth = sb16.size();
    endcase
    if (depth == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: scoreboard empty, observed q %0h expected an entry", tag, obs_q(inst));
    end else begin
      case (inst)
        0:       e = sb1.pop_front();
        1:       e = sb8.pop_front();
        default: e = sb16.pop_front();
      endcase
      check({tag, "_vld"}, 64'(obs_v(inst)), 64'(e.vld));
      check({tag, "_q"}, obs_q(inst), e.q);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rv;
    logic [7:0]  s_a [4];
    logic [7:0]  s_b [4];

    a1 = '0; b1 = '0; v1 = 1'b0;
    a8 = '0; b8 = '0; v8 = 1'b0;
    a16 = '0; b16 = '0; v16 = 1'b0;
    sb_clear();

    // Reset state of every instance.
    #1;
    check("rst_q1", 64'(q1), 64'd0);
    check("rst_v1", 64'(ov1), 64'd0);
    check("rst_q8", 64'(q8), 64'd0);
    check("rst_v8", 64'(ov8), 64'd0);
    check("rst_q16", 64'(q16), 64'd0);
    check("rst_v16", 64'(ov16), 64'd0);

    // Exhaustive 1-bit truth table while held in reset.
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #1;
      check($sformatf("comb_rst_%0d", i), 64'(o1), 64'(a1 ^ b1));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, out of reset, against fixed golden values.
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #1;
      check($sformatf("comb_%0d", i), 64'(o1), (i == 1 || i == 2) ? 64'd1 : 64'd0);
    end

    // Registered capture then hold with in_valid low.
    drive(0, 64'd1, 64'd0, 1'b1, "cap");
    sample(0, "cap");
    check("cap_gold_q", 64'(q1), 64'd1);
    drive(0, 64'd1, 64'd1, 1'b0, "hold");
    sample(0, "hold");
    check("hold_gold_q", 64'(q1), 64'd1);

    // Asynchronous reset between clock edges while o keeps tracking a^b.
    drive(0, 64'd0, 64'd1, 1'b1, "pre_arst");
    sample(0, "pre_arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q1", 64'(q1), 64'd0);
    check("arst_v1", 64'(ov1), 64'd0);
    a1 = 1'b1;
    b1 = 1'b0;
    #1;
    check("arst_o1", 64'(o1), 64'd1);
    sb_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back streaming at WIDTH=8 with golden result values.
    s_a = '{8'hFF, 8'hAA, 8'h00, 8'h3C};
    s_b = '{8'h0F, 8'h55, 8'h00, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(s_a[i]), 64'(s_b[i]), 1'b1, $sformatf("strm%0d", i));
      sample(1, $sformatf("strm%0d", i));
      check($sformatf("strm%0d_gold", i), 64'(q8),
            (i == 0) ? 64'hF0 : (i == 1) ? 64'hFF : 64'h00);
    end
    drive(1, 64'h12, 64'h34, 1'b0, "strm_idle");
    sample(1, "strm_idle");

    // Reset released on a rising edge: that edge must still see reset.
    @(negedge clk);
    rst_n = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    v1 = 1'b1;
    sb_clear();
    @(posedge clk);
    rst_n <= 1'b1;  // lands after this edge has sampled rst_n low
    #1;
    check("rel_edge_q1", 64'(q1), 64'd0);
    check("rel_edge_v1", 64'(ov1), 64'd0);
    @(posedge clk);
    #1;
    check("rel_next_q1", 64'(q1), 64'd1);
    check("rel_next_v1", 64'(ov1), 64'd1);
    @(negedge clk);
    v1 = 1'b0;

    // Randomised WIDTH=16 against the one-cycle reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 64'($urandom_range(0, 65535));
      rb = 64'($urandom_range(0, 65535));
      rv = 1'($urandom_range(0, 1));
      drive(2, ra, rb, rv, "rnd");
      sample(2, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
